// File: rtl/blockram_bus_arbiter_if.sv
// blockram_bus_arbiter_if
// Bundles the two requesting masters and the asynchronous memory bus.
// The memory bus uses address/data strobes and an active-low DTACK.
//   m<n>_req/adr/rwn/be/wdata : request side of master n (rwn=1 is a read,
//                               be[3] enables the byte at the aligned address)
//   m<n>_ack/err/rdata        : completion pulses and read data back to master n
//   ADR_OUT/DATA_OUT          : address and write data presented to memory
//   ASn/RWn/UDS/LDS/UDS2/LDS2 : memory strobes, all active-low except RWn
//   DATA_IN/DTACK             : read data and active-low acknowledge from memory
//   busy                      : arbiter is not idle
// Modport slave is the arbiter's view. Modport master is the view of whatever
// drives the requests and models the memory.
interface blockram_bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_adr;
  logic        m0_rwn;
  logic [3:0]  m0_be;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_adr;
  logic        m1_rwn;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic [31:0] ADR_OUT;
  logic [31:0] DATA_OUT;
  logic        ASn;
  logic        RWn;
  logic        UDS;
  logic        LDS;
  logic        UDS2;
  logic        LDS2;
  logic [31:0] DATA_IN;
  logic        DTACK;
  logic        busy;

  modport slave (
    input  m0_req, m0_adr, m0_rwn, m0_be, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_adr, m1_rwn, m1_be, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output ADR_OUT, DATA_OUT, ASn, RWn, UDS, LDS, UDS2, LDS2,
    input  DATA_IN, DTACK,
    output busy
  );

  modport master (
    output m0_req, m0_adr, m0_rwn, m0_be, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_adr, m1_rwn, m1_be, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  ADR_OUT, DATA_OUT, ASn, RWn, UDS, LDS, UDS2, LDS2,
    output DATA_IN, DTACK,
    input  busy
  );
endinterface

// File: rtl/blockram_bus_arbiter.sv
// blockram_bus_arbiter
// Arbitrates two masters onto one asynchronous memory bus using round-robin.
// The bus has an address strobe and four active-low byte strobes. Memory
// completes a cycle by pulling DTACK low.
// A granted request is copied into holding registers. The copy drives the bus
// for the whole access, so the master's inputs may change during the access.
// An access ends when DTACK is seen low (ack), or after TIMEOUT cycles without
// DTACK (err). The arbiter then waits in RECOVER until DTACK is released.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : blockram_bus_arbiter_if.slave (master handshakes, memory bus, busy)
module blockram_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  blockram_bus_arbiter_if.slave bus
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  // last_grant_r is the master last granted. During an access it is also the
  // master being served.
  logic             last_grant_r;
  logic [31:0]      adr_r;
  logic [31:0]      wdata_r;
  logic             rwn_r;
  logic [3:0]       be_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;

  logic             asn_r;
  logic             rwn_out_r;
  logic [3:0]       strb_r;       // {UDS, LDS, UDS2, LDS2}
  logic             busy_r;
  logic             m0_ack_r;
  logic             m0_err_r;
  logic             m1_ack_r;
  logic             m1_err_r;
  logic [31:0]      m0_rdata_r;
  logic [31:0]      m1_rdata_r;

  logic             load_s;
  logic             gnt_sel_s;
  logic             ack_s;
  logic             err_s;
  logic [31:0]      sel_adr_s;
  logic [31:0]      sel_wdata_s;
  logic             sel_rwn_s;
  logic [3:0]       sel_be_s;
  logic             rwn_hold_next_s;
  logic [3:0]       be_hold_next_s;
  logic             asn_next_s;
  logic             rwn_out_next_s;
  logic [3:0]       strb_next_s;

  // Saturating increment of the access-cycle counter (it never wraps)
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r != CNT_MAX) begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end else begin
      cnt_inc_s = cnt_r;
    end
  end

  // Next-state, grant selection and completion decode
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    gnt_sel_s    = last_grant_r;
    ack_s        = 1'b0;
    err_s        = 1'b0;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          load_s       = 1'b1;
          state_next_s = ST_ACCESS;
          cnt_next_s   = CNT_ZERO;
          // On a tie, the master that was not granted last wins
          if (bus.m0_req && bus.m1_req) begin
            gnt_sel_s = ~last_grant_r;
          end else if (bus.m1_req) begin
            gnt_sel_s = 1'b1;
          end else begin
            gnt_sel_s = 1'b0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!bus.DTACK) begin
          ack_s        = 1'b1;
          state_next_s = ST_RECOVER;
        end else if (cnt_inc_s >= CNT_LIMIT) begin
          err_s        = 1'b1;
          state_next_s = ST_RECOVER;
          cnt_next_s   = cnt_inc_s;
        end else begin
          cnt_next_s   = cnt_inc_s;
        end
      end
      ST_RECOVER: begin
        if (bus.DTACK) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RECOVER;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Request fields of the master selected for grant
  always_comb begin
    sel_adr_s   = bus.m0_adr;
    sel_wdata_s = bus.m0_wdata;
    sel_rwn_s   = bus.m0_rwn;
    sel_be_s    = bus.m0_be;
    if (gnt_sel_s) begin
      sel_adr_s   = bus.m1_adr;
      sel_wdata_s = bus.m1_wdata;
      sel_rwn_s   = bus.m1_rwn;
      sel_be_s    = bus.m1_be;
    end else begin
      sel_adr_s   = bus.m0_adr;
      sel_wdata_s = bus.m0_wdata;
      sel_rwn_s   = bus.m0_rwn;
      sel_be_s    = bus.m0_be;
    end
  end

  // Bus strobe values for the next cycle, decoded from the next state so
  // that the registered strobes line up with the state register
  always_comb begin
    rwn_hold_next_s = load_s ? sel_rwn_s : rwn_r;
    be_hold_next_s  = load_s ? sel_be_s  : be_r;
    asn_next_s      = 1'b1;
    rwn_out_next_s  = 1'b1;
    strb_next_s     = 4'b1111;
    if (state_next_s == ST_ACCESS) begin
      asn_next_s     = 1'b0;
      rwn_out_next_s = rwn_hold_next_s;
      if (rwn_hold_next_s) begin
        strb_next_s = 4'b0000;
      end else begin
        strb_next_s = ~be_hold_next_s;
      end
    end else begin
      asn_next_s     = 1'b1;
      rwn_out_next_s = 1'b1;
      strb_next_s    = 4'b1111;
    end
  end

  // State, holding registers, bus strobes and per-master completion registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      adr_r        <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      rwn_r        <= 1'b1;
      be_r         <= 4'b0000;
      cnt_r        <= CNT_ZERO;
      asn_r        <= 1'b1;
      rwn_out_r    <= 1'b1;
      strb_r       <= 4'b1111;
      busy_r       <= 1'b0;
      m0_ack_r     <= 1'b0;
      m0_err_r     <= 1'b0;
      m1_ack_r     <= 1'b0;
      m1_err_r     <= 1'b0;
      m0_rdata_r   <= 32'h0000_0000;
      m1_rdata_r   <= 32'h0000_0000;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
      asn_r     <= asn_next_s;
      rwn_out_r <= rwn_out_next_s;
      strb_r    <= strb_next_s;
      // Holding registers load only on the grant edge
      if (load_s) begin
        last_grant_r <= gnt_sel_s;
        adr_r        <= sel_adr_s;
        wdata_r      <= sel_wdata_s;
        rwn_r        <= sel_rwn_s;
        be_r         <= sel_be_s;
      end
      m0_ack_r <= ack_s & ~last_grant_r;
      m1_ack_r <= ack_s &  last_grant_r;
      m0_err_r <= err_s & ~last_grant_r;
      m1_err_r <= err_s &  last_grant_r;
      if (ack_s && rwn_r && !last_grant_r) begin
        m0_rdata_r <= bus.DATA_IN;
      end
      if (ack_s && rwn_r && last_grant_r) begin
        m1_rdata_r <= bus.DATA_IN;
      end
    end
  end

  assign bus.ADR_OUT  = adr_r;
  assign bus.DATA_OUT = wdata_r;
  assign bus.ASn      = asn_r;
  assign bus.RWn      = rwn_out_r;
  assign bus.UDS      = strb_r[3];
  assign bus.LDS      = strb_r[2];
  assign bus.UDS2     = strb_r[1];
  assign bus.LDS2     = strb_r[0];
  assign bus.busy     = busy_r;
  assign bus.m0_ack   = m0_ack_r;
  assign bus.m0_err   = m0_err_r;
  assign bus.m0_rdata = m0_rdata_r;
  assign bus.m1_ack   = m1_ack_r;
  assign bus.m1_err   = m1_err_r;
  assign bus.m1_rdata = m1_rdata_r;

endmodule

// File: tb/tb_blockram_bus_arbiter.sv
// tb_blockram_bus_arbiter
// Directed bench for blockram_bus_arbiter. The memory model adds one wait
// state: DTACK falls one cycle after ASn falls and rises as soon as ASn rises.
// Holding dtack_block forces DTACK high, which provokes a timeout.
// The memory is reinitialised whenever reset is high.
module tb_blockram_bus_arbiter;
  logic clk;
  logic reset;
  logic dtack_block;
  logic seen_r;
  logic [31:0] mem [0:15];

  int checks;
  int errors;
  int who;
  int kind;
  int cyc;
  int low_cnt;
  logic saw_bad;

  blockram_bus_arbiter_if bus ();

  blockram_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-wait-state memory with byte strobes (UDS = byte at the aligned address)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_r <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_0000;
      mem[4]  <= 32'hDEAD_BEEF;
      mem[8]  <= 32'hAABB_CCDD;
      mem[12] <= 32'h0BAD_F00D;
    end else begin
      seen_r <= ~bus.ASn;
      if (!bus.ASn && !bus.RWn && !seen_r && !dtack_block) begin
        if (!bus.UDS)  mem[bus.ADR_OUT[5:2]][31:24] <= bus.DATA_OUT[31:24];
        if (!bus.LDS)  mem[bus.ADR_OUT[5:2]][23:16] <= bus.DATA_OUT[23:16];
        if (!bus.UDS2) mem[bus.ADR_OUT[5:2]][15:8]  <= bus.DATA_OUT[15:8];
        if (!bus.LDS2) mem[bus.ADR_OUT[5:2]][7:0]   <= bus.DATA_OUT[7:0];
      end
    end
  end

  assign bus.DTACK   = dtack_block | bus.ASn | ~seen_r;
  assign bus.DATA_IN = mem[bus.ADR_OUT[5:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait, within a cycle budget, for an ack or err. On return, who is the
  // master (-1 if the budget ran out) and kind is 1 for ack or 2 for err.
  task automatic wait_event(input int max_cyc, output int w, output int k);
    w = -1;
    k = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m0_err || bus.m1_ack || bus.m1_err) begin
        w = (bus.m1_ack || bus.m1_err) ? 1 : 0;
        k = (bus.m0_err || bus.m1_err) ? 2 : 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    dtack_block = 1'b0;
    bus.m0_req = 1'b0; bus.m0_adr = 32'h0; bus.m0_rwn = 1'b1; bus.m0_be = 4'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_adr = 32'h0; bus.m1_rwn = 1'b1; bus.m1_be = 4'h0; bus.m1_wdata = 32'h0;

    // Reset state
    #2;
    chk("rst_asn", bus.ASn, 32'd1);
    chk("rst_strobes", {bus.RWn, bus.UDS, bus.LDS, bus.UDS2, bus.LDS2}, 32'h1F);
    chk("rst_adr", bus.ADR_OUT, 32'h0);
    chk("rst_busy", bus.busy, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single read: m0 reads 0x10
    bus.m0_req = 1'b1; bus.m0_adr = 32'h10; bus.m0_rwn = 1'b1; bus.m0_be = 4'hF;
    @(negedge clk);
    chk("rd_asn_c1", bus.ASn, 32'd0);
    chk("rd_adr", bus.ADR_OUT, 32'h10);
    chk("rd_strobes", {bus.RWn, bus.UDS, bus.LDS, bus.UDS2, bus.LDS2}, 32'h10);
    chk("rd_busy", bus.busy, 32'd1);
    @(negedge clk);
    chk("rd_asn_c2", bus.ASn, 32'd0);
    chk("rd_ack_early", bus.m0_ack, 32'd0);
    @(negedge clk);
    chk("rd_ack", {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err}, 32'b1000);
    chk("rd_data", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("rd_asn_high", bus.ASn, 32'd1);
    bus.m0_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", bus.m0_ack, 32'd0);
    chk("rd_busy_low", bus.busy, 32'd0);

    // Byte write: m1 writes 0x11223344 to 0x20 with be=0100
    bus.m1_req = 1'b1; bus.m1_adr = 32'h20; bus.m1_rwn = 1'b0; bus.m1_be = 4'b0100; bus.m1_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("wr_strobes", {bus.ASn, bus.RWn, bus.UDS, bus.LDS, bus.UDS2, bus.LDS2}, 32'b001011);
    chk("wr_data_out", bus.DATA_OUT, 32'h1122_3344);
    wait_event(10, who, kind);
    chk("wr_who", who, 32'd1);
    chk("wr_kind", kind, 32'd1);
    bus.m1_req = 1'b0;
    @(negedge clk);
    chk("wr_mem", mem[8], 32'hAA22_CCDD);
    chk("wr_m0_rdata_kept", bus.m0_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // Input stability: change m0 inputs during the access
    bus.m0_req = 1'b1; bus.m0_adr = 32'h34; bus.m0_rwn = 1'b0; bus.m0_be = 4'hF; bus.m0_wdata = 32'h5566_7788;
    @(negedge clk);
    bus.m0_adr = 32'h04; bus.m0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stab_adr", bus.ADR_OUT, 32'h34);
    chk("stab_data", bus.DATA_OUT, 32'h5566_7788);
    wait_event(10, who, kind);
    chk("stab_who", who, 32'd0);
    bus.m0_req = 1'b0;
    @(negedge clk);
    chk("stab_mem", mem[13], 32'h5566_7788);
    @(negedge clk);

    // Contention from reset: both masters request continuously
    reset = 1'b1;
    bus.m0_adr = 32'h10; bus.m0_rwn = 1'b1;
    bus.m1_adr = 32'h20; bus.m1_rwn = 1'b1; bus.m1_be = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_event(12, who, kind);
      chk("cont_who", who, k % 2);
      chk("cont_single", $countones({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err}), 32'd1);
      chk("cont_rdata", (k % 2 == 0) ? bus.m0_rdata : bus.m1_rdata, (k % 2 == 0) ? 32'hDEAD_BEEF : 32'hAABB_CCDD);
      chk("cont_asn_gap", bus.ASn, 32'd1);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("cont_idle", bus.busy, 32'd0);

    // Timeout: DTACK held high
    dtack_block = 1'b1;
    bus.m0_req = 1'b1; bus.m0_adr = 32'h10; bus.m0_rwn = 1'b1;
    low_cnt = 0; who = -1; saw_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.ASn) low_cnt++;
      if (bus.m0_ack || bus.m1_ack || bus.m1_err) saw_bad = 1'b1;
      if (bus.m0_err) begin
        who = 0;
        break;
      end
    end
    chk("to_err_seen", who, 32'd0);
    chk("to_asn_low_cycles", low_cnt, 32'd16);
    chk("to_no_ack", saw_bad, 32'd0);
    chk("to_asn_high", bus.ASn, 32'd1);
    chk("to_rdata_kept", bus.m0_rdata, 32'hDEAD_BEEF);
    bus.m0_req = 1'b0;
    dtack_block = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", bus.m0_err, 32'd0);
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_adr = 32'h30;
    wait_event(10, who, kind);
    chk("to_next_kind", kind, 32'd1);
    chk("to_next_rdata", bus.m0_rdata, 32'h0BAD_F00D);
    bus.m0_req = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset mid-access
    bus.m1_req = 1'b1; bus.m1_adr = 32'h20; bus.m1_rwn = 1'b1;
    @(negedge clk);
    chk("mid_asn_low", bus.ASn, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_asn", bus.ASn, 32'd1);
    chk("mid_strobes", {bus.RWn, bus.UDS, bus.LDS, bus.UDS2, bus.LDS2}, 32'h1F);
    chk("mid_adr_data", {bus.ADR_OUT, bus.DATA_OUT} == 64'h0, 32'd1);
    chk("mid_rdata", {bus.m0_rdata, bus.m1_rdata} == 64'h0, 32'd1);
    chk("mid_busy", bus.busy, 32'd0);
    bus.m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    saw_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m0_err || bus.m1_ack || bus.m1_err || !bus.ASn) saw_bad = 1'b1;
    end
    chk("mid_no_event", saw_bad, 32'd0);
    bus.m0_req = 1'b1; bus.m0_adr = 32'h10;
    wait_event(10, who, kind);
    chk("mid_after_who", who, 32'd0);
    chk("mid_after_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    bus.m0_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
